fios_result_collector: RTL and testbench
========================================

Name: fios_result_collector

Overview:
- Downstream consumer of the last PE in the no-cascade FIOS Montgomery multiplier chain.
- Captures the 17-bit result words (RES_o) the chain emits least-significant word first, one word per valid strobe.
- Runs a word-serial final conditional subtraction (result >= p ? result - p : result).
- Presents the fully reduced product as one parallel vector under a valid/ready handshake.

Parameters:
- WORD_WIDTH, 17, width of one result/modulus word; matches the DSP 17-bit limb.
- NUM_WORDS, 16, number of words per product (S); result width = NUM_WORDS*WORD_WIDTH.
- CNT_WIDTH, $clog2(NUM_WORDS+1), width of the internal word counter; derived, never overridden.

Ports:
- clock_i  input  1  system clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- res_valid_i  input  1  qualifies res_i for the current cycle; driven by the chain controller.
- res_i  input  WORD_WIDTH  result word from the last PE, LSW first.
- p_i  input  NUM_WORDS*WORD_WIDTH  modulus; must be held stable from the first captured word until result handshake.
- collect_ready_o  output  1  high in COLLECT state (status only; the chain cannot stall).
- result_o  output  NUM_WORDS*WORD_WIDTH  reduced product.
- result_valid_o  output  1  result_o valid.
- result_ready_i  input  1  consumer accepts result_o.
- overflow_o  output  1  sticky error: a word arrived while not in COLLECT.

Behaviour:
- Reset (async, any state): state=COLLECT, word counter=0, borrow=0, res/diff buffers=0; result_o=0, result_valid_o=0, overflow_o=0, collect_ready_o=1 as soon as reset deasserts.
- COLLECT:
  - res_valid_i=1 writes res_i into res_buf[cnt], cnt++.
  - When the word written is index NUM_WORDS-1: cnt<=0, borrow<=0, go to SUBTRACT next cycle.
  - res_valid_i=0 holds all state; gaps between words are allowed.
- SUBTRACT, one word per cycle, k = cnt:
  - {b_out, d} = res_buf[k] - p_i[k] - borrow, computed in WORD_WIDTH+1 bits.
  - diff_buf[k] <= d[WORD_WIDTH-1:0]; borrow <= b_out; cnt++.
  - Runs exactly NUM_WORDS cycles, then go to OUTPUT.
  - On entering OUTPUT: result_o <= final borrow ? res_buf : diff_buf, and result_valid_o <= 1.
  - res >= p selects diff; res == p yields 0.
- OUTPUT:
  - result_valid_o stays high; result_o stays stable until a cycle with result_ready_i=1.
  - On that cycle: result_valid_o <= 0, cnt <= 0, go to COLLECT.
  - result_o keeps its last value after the handshake.
- Latency: last word captured at edge t -> result_valid_o high after edge t+NUM_WORDS+1 (NUM_WORDS subtract cycles plus 1 select/register cycle). Throughput: one product per NUM_WORDS+1 cycles plus collection time.
- res_valid_i=1 in SUBTRACT or OUTPUT:
  - The word is dropped; no buffer or counter change.
  - overflow_o <= 1 and stays set until reset.
- Handshake-cycle collision: in the cycle result_ready_i completes the handshake, res_valid_i counts as an overflow, because the state is still OUTPUT.
- No wrap-around of cnt: it is cleared on every state exit; values >= NUM_WORDS are unreachable.
- Reset mid-COLLECT or mid-SUBTRACT: partial words are discarded; the next frame starts at index 0.
- Widths: all arithmetic is unsigned. The result is treated as NUM_WORDS*WORD_WIDTH bits, and an input result < 2p is required for a single subtraction to reduce fully.

Test Plan:
- Reset: assert reset_i mid-SUBTRACT -> result_valid_o=0, overflow_o=0, result_o=0, and collect_ready_o=1 immediately and asynchronously.
- NUM_WORDS=2, p={0x00003,0x00005}, words 0x00007 then 0x00003 -> result_o=0x2, result_valid_o rises exactly 3 edges after the second word.
- Same p, words 0x00004 then 0x00003 (res<p, intermediate word 0x1FFFF with borrow) -> result_o=0x60004 (unsubtracted).
- Same p, words 0x00005 then 0x00003 (res==p) -> result_o=0x0.
- Backpressure: hold result_ready_i=0 for 10 cycles and pulse res_valid_i twice during OUTPUT -> result_o stable, overflow_o=1 sticky, next frame captured from index 0 after the handshake.
- Gapped input plus reset: word 0x00001, 5 idle cycles, reset_i pulse, then full frame 0x00007/0x00003 -> pre-reset word ignored, result_o=0x2.

Source files
------------

// File: rtl/fios_result_collector.sv
// fios_result_collector
// Collects the result words that the last PE of the FIOS Montgomery chain
// emits, least-significant word first. Once a full product has arrived it
// runs a word-serial conditional subtraction of the modulus and presents the
// fully reduced product as one parallel vector under a valid/ready handshake.
//
// Ports:
//   clock_i          system clock, rising edge
//   reset_i          asynchronous active-high reset
//   res_valid_i      res_i qualifier from the chain controller
//   res_i            one result word, LSW first
//   p_i              modulus, held stable from first word until handshake
//   collect_ready_o  high while collecting (status only, chain cannot stall)
//   result_o         reduced product
//   result_valid_o   result_o valid
//   result_ready_i   consumer accepts result_o
//   overflow_o       sticky: a word arrived while not collecting
//
// state    | meaning
// ---------+-----------------------------------------------------------
// COLLECT  | capture words into res_buf, cnt = next word index
// SUBTRACT | one word of res_buf - p per cycle into diff_buf, cnt = word
// OUTPUT   | first cycle selects res/diff into result_o, then wait ready
module fios_result_collector #(
  parameter  int WORD_WIDTH = 17,
  parameter  int NUM_WORDS  = 16,
  localparam int CNT_WIDTH  = $clog2(NUM_WORDS + 1),
  localparam int RES_WIDTH  = NUM_WORDS * WORD_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  res_valid_i,
  input  logic [WORD_WIDTH-1:0] res_i,
  input  logic [RES_WIDTH-1:0]  p_i,
  output logic                  collect_ready_o,
  output logic [RES_WIDTH-1:0]  result_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_SUBTRACT = 2'd1,
    ST_OUTPUT   = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   borrow_q, borrow_d;
  logic [RES_WIDTH-1:0]   res_buf_q, res_buf_d;
  logic [RES_WIDTH-1:0]   diff_buf_q, diff_buf_d;
  logic [RES_WIDTH-1:0]   result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic                   overflow_q, overflow_d;

  logic                   last_word;
  logic [WORD_WIDTH-1:0]  res_word;
  logic [WORD_WIDTH-1:0]  p_word;
  logic [WORD_WIDTH:0]    sub_full;

  // State and datapath registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= ST_COLLECT;
      cnt_q          <= '0;
      borrow_q       <= 1'b0;
      res_buf_q      <= '0;
      diff_buf_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      borrow_q       <= borrow_d;
      res_buf_q      <= res_buf_d;
      diff_buf_q     <= diff_buf_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign last_word = (cnt_q == LAST_IDX);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT:  if (res_valid_i && last_word) state_d = ST_SUBTRACT;
      ST_SUBTRACT: if (last_word) state_d = ST_OUTPUT;
      ST_OUTPUT:   if (result_valid_q && result_ready_i) state_d = ST_COLLECT;
      default:     state_d = ST_COLLECT;
    endcase
  end

  // Datapath next values
  always_comb begin
    cnt_d          = cnt_q;
    borrow_d       = borrow_q;
    res_buf_d      = res_buf_q;
    diff_buf_d     = diff_buf_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    // Any word outside COLLECT is dropped and flagged until reset.
    overflow_d     = overflow_q | (res_valid_i && (state_q != ST_COLLECT));

    res_word = res_buf_q[cnt_q * WORD_WIDTH +: WORD_WIDTH];
    p_word   = p_i[cnt_q * WORD_WIDTH +: WORD_WIDTH];
    // One extra bit on top catches the borrow out of this word.
    sub_full = {1'b0, res_word} - {1'b0, p_word} - {{WORD_WIDTH{1'b0}}, borrow_q};

    case (state_q)
      ST_COLLECT: begin
        if (res_valid_i) begin
          res_buf_d[cnt_q * WORD_WIDTH +: WORD_WIDTH] = res_i;
          if (last_word) begin
            cnt_d    = '0;
            borrow_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      ST_SUBTRACT: begin
        diff_buf_d[cnt_q * WORD_WIDTH +: WORD_WIDTH] = sub_full[WORD_WIDTH-1:0];
        borrow_d = sub_full[WORD_WIDTH];
        cnt_d    = last_word ? '0 : cnt_q + CNT_WIDTH'(1);
      end
      ST_OUTPUT: begin
        if (!result_valid_q) begin
          // A final borrow means res < p, so the unsubtracted value is reduced.
          result_d       = borrow_q ? res_buf_q : diff_buf_q;
          result_valid_d = 1'b1;
        end else if (result_ready_i) begin
          result_valid_d = 1'b0;
          cnt_d          = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    collect_ready_o = (state_q == ST_COLLECT);
  end

  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_fios_result_collector.sv
module tb_fios_result_collector;

  localparam int W   = 17;
  localparam int N   = 2;
  localparam int RW  = N * W;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          res_valid_i = 1'b0;
  logic [W-1:0]  res_i = '0;
  logic [RW-1:0] p_i;
  logic          collect_ready_o;
  logic [RW-1:0] result_o;
  logic          result_valid_o;
  logic          result_ready_i = 1'b0;
  logic          overflow_o;

  int vectors = 0;
  int miscompares = 0;
  logic [RW-1:0] sb[$];

  fios_result_collector #(.WORD_WIDTH(W), .NUM_WORDS(N)) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .res_valid_i     (res_valid_i),
    .res_i           (res_i),
    .p_i             (p_i),
    .collect_ready_o (collect_ready_o),
    .result_o        (result_o),
    .result_valid_o  (result_valid_o),
    .result_ready_i  (result_ready_i),
    .overflow_o      (overflow_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; the word is captured on the next edge.
  task automatic send_word(input logic [W-1:0] w);
    res_valid_i = 1'b1;
    res_i       = w;
    @(posedge clock_i); #1;
    res_valid_i = 1'b0;
    res_i       = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_i); #1;
    end
  endtask

  // Wait for result_valid_o, report edges taken since the last captured word.
  task automatic wait_result(input string tag, input int exp_edges);
    int edges;
    logic [RW-1:0] exp;
    edges = 0;
    while (!result_valid_o && edges < 50) begin
      @(posedge clock_i); #1;
      edges++;
    end
    check({tag, "_latency"}, edges, exp_edges);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_result"}, result_o, exp);
    end
  endtask

  task automatic handshake(input string tag);
    result_ready_i = 1'b1;
    @(posedge clock_i); #1;
    result_ready_i = 1'b0;
    check({tag, "_valid_drop"}, result_valid_o, 1'b0);
    check({tag, "_collect_ready"}, collect_ready_o, 1'b1);
  endtask

  initial begin
    logic [RW-1:0] held;
    p_i = {17'h00003, 17'h00005};

    idle(2);
    check("rst_valid", result_valid_o, 1'b0);
    check("rst_result", result_o, '0);
    check("rst_overflow", overflow_o, 1'b0);
    check("rst_collect_ready", collect_ready_o, 1'b1);
    reset_i = 1'b0;
    idle(1);

    // res > p
    send_word(17'h00007);
    send_word(17'h00003);
    sb.push_back(34'h2);
    wait_result("gt", 3);
    handshake("gt");

    // res < p, borrow chain through 0x1FFFF
    send_word(17'h00004);
    send_word(17'h00003);
    sb.push_back(34'h60004);
    wait_result("lt", 3);
    handshake("lt");

    // res == p
    send_word(17'h00005);
    send_word(17'h00003);
    sb.push_back(34'h0);
    wait_result("eq", 3);
    handshake("eq");

    // Backpressure with words arriving during OUTPUT
    send_word(17'h00004);
    send_word(17'h00003);
    sb.push_back(34'h60004);
    wait_result("bp", 3);
    held = result_o;
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 6) begin
        send_word(17'h1FFFF);
      end else begin
        idle(1);
      end
      check("bp_stable", result_o, held);
      check("bp_valid_held", result_valid_o, 1'b1);
    end
    check("bp_overflow", overflow_o, 1'b1);
    handshake("bp");
    send_word(17'h00007);
    send_word(17'h00003);
    sb.push_back(34'h2);
    wait_result("bp_next", 3);
    check("bp_overflow_sticky", overflow_o, 1'b1);
    handshake("bp_next");

    // Reset in the middle of SUBTRACT
    send_word(17'h00004);
    send_word(17'h00003);
    idle(1);
    check("mid_sub_collect_ready", collect_ready_o, 1'b0);
    reset_i = 1'b1;
    #1;
    check("arst_valid", result_valid_o, 1'b0);
    check("arst_overflow", overflow_o, 1'b0);
    check("arst_result", result_o, '0);
    check("arst_collect_ready", collect_ready_o, 1'b1);
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    idle(1);

    // Gapped partial frame discarded by reset
    send_word(17'h00001);
    idle(5);
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
    @(posedge clock_i); #1;
    send_word(17'h00007);
    send_word(17'h00003);
    sb.push_back(34'h2);
    wait_result("gap", 3);
    check("gap_overflow", overflow_o, 1'b0);
    handshake("gap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
